config_loader: RTL and testbench
================================

# config_loader

Sequencer that owns the fabric-wide configuration bus. It accepts a byte-serial bitstream over a valid/ready handshake, assembles (address, data) records, and broadcasts each record on `config_addr`/`config_data` to every PE tile for a programmable number of cycles. Each tile's address matchers decode `config_addr[15:0]` as the tile id and `config_addr[31:16]` as the module id. Between writes the block drives a null address, so no tile's configuration enable is ever asserted spuriously.

## Interface
- `HOLD_CYCLES`, default 1: cycles each record is driven on the config bus (legal range 1..15).
- `IDLE_ADDR`, default 32'h0000_0000: address driven whenever no write is in progress. Module id 0 matches no tile matcher.
- `clk`, input, 1: fabric clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `start`, input, 1: begin loading a bitstream; sampled only in IDLE or DONE.
- `in_data`, input, 8: bitstream byte.
- `in_valid`, input, 1: `in_data` valid.
- `in_ready`, output, 1: loader can accept a byte.
- `config_addr`, output, 32: broadcast configuration address.
- `config_data`, output, 32: broadcast configuration data.
- `busy`, output, 1: high in every state except IDLE and DONE.
- `done`, output, 1: level, high in DONE.
- `writes_issued`, output, 16: records broadcast since the last `start`.

## Operation
- Stream format: 2-byte record count N (LSB first), then N records. Each record is 4 address bytes (LSB first) followed by 4 data bytes (LSB first).
- A byte is accepted on a cycle where `in_valid && in_ready`.
- States:
  - IDLE: `in_ready`=0. `start` -> HDR.
  - HDR: `in_ready`=1. Accept 2 bytes into the count. After the 2nd byte: N=0 -> DONE, else -> ADDR.
  - ADDR: `in_ready`=1. Accept 4 bytes into the address shift register, then -> DATA.
  - DATA: `in_ready`=1. Accept 4 bytes into the data shift register, then -> ISSUE.
  - ISSUE: `in_ready`=0. `config_addr`/`config_data` = assembled record for exactly HOLD_CYCLES cycles, then -> GAP.
  - GAP: `in_ready`=0. One cycle; `config_addr`=IDLE_ADDR, `config_data`=0. Increment `writes_issued`. Go to DONE if `writes_issued`+1 == N, else ADDR.
  - DONE: `done`=1, `in_ready`=0. `start` -> HDR; `writes_issued` clears to 0 on that transition.
- Outside ISSUE: `config_addr`=IDLE_ADDR, `config_data`=0. Assembly registers never appear on the bus until ISSUE.
- `start` in any busy state is ignored.
- Byte counters are 2-bit (address/data) and 1-bit (header). They wrap to 0 on each state exit.
- `writes_issued` is 16-bit. N ≤ 65535, so it cannot overflow within a stream.
- The hold counter is 4-bit and counts down from HOLD_CYCLES-1.

## Timing
- Reset (`reset`=0 at a clock edge): next cycle the state is IDLE and all outputs are 0 (`config_addr`=IDLE_ADDR). All byte, hold and record counters clear.
- Reset mid-ISSUE removes the address from the bus on the next cycle. The partial record is discarded.
- `in_ready` is a registered function of state only, not of `in_valid`. Stalls (`in_valid`=0) hold all state indefinitely.
- If the 8th record byte is accepted at edge t, ISSUE drives the bus from cycle t+1 through t+HOLD_CYCLES. GAP is cycle t+HOLD_CYCLES+1. `in_ready` returns high at cycle t+HOLD_CYCLES+2.
- Minimum period per record: 8 + HOLD_CYCLES + 1 cycles.
- `start` accepted at edge t: `busy`=1 and `in_ready`=1 from cycle t+1.
- `done` rises the cycle after the final GAP, or after the 2nd header byte when N=0.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `in_valid`=1 and random data. Required: `in_ready`=0, `busy`=0, `done`=0, `config_addr`=0, `config_data`=0, `writes_issued`=0.
- Single record: HOLD_CYCLES=1, stream 01 00 | 07 00 10 00 | 03 00 00 00. Required: exactly one cycle with `config_addr`=32'h0010_0007 and `config_data`=32'h3, then `config_addr`=0. `done`=1 and `writes_issued`=1 afterward.
- Back-to-back with stalls: N=3, HOLD_CYCLES=2, random `in_valid` gaps. Required: three bus windows of 2 cycles each, in stream order. Each window is separated by at least one IDLE_ADDR cycle. `writes_issued` reads 1, 2, 3.
- Empty stream: bytes 00 00. Required: `done`=1 the cycle after the 2nd byte, and no non-zero `config_addr` at any point.
- Reset mid-ISSUE: HOLD_CYCLES=4, assert reset on the 2nd hold cycle. Required: `config_addr`=0 from the next cycle; a fresh `start` with a full stream then loads correctly.
- Restart/ignore: pulse `start` while in DATA. Required: no effect. Then `start` in DONE: `writes_issued` clears to 0 and HDR is entered.

Source files
------------

// File: rtl/config_loader_if.sv
// config_loader_if: byte-serial bitstream handshake into the configuration loader.
//   in_data  : bitstream byte (master -> slave)
//   in_valid : in_data valid (master -> slave)
//   in_ready : loader can accept a byte (slave -> master)
// A byte transfers on a rising edge where in_valid && in_ready.
interface config_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/config_loader.sv
// config_loader: owns the fabric configuration bus. It takes a byte-serial bitstream
// (16-bit record count, then count x {addr[31:0], data[31:0]}, all LSB first), and drives
// each record on the broadcast bus for HOLD_CYCLES cycles, followed by one null cycle.
//   i_clk           : fabric clock
//   i_reset         : synchronous, active-low reset
//   i_start         : begin a bitstream load (honoured only in IDLE or DONE)
//   s_in            : bitstream byte handshake (slave side)
//   o_config_addr   : broadcast address, IDLE_ADDR whenever no write is in progress
//   o_config_data   : broadcast data, zero whenever no write is in progress
//   o_busy          : high in every state except IDLE and DONE
//   o_done          : high in DONE
//   o_writes_issued : records broadcast since the last start
module config_loader #(
   parameter int unsigned HOLD_CYCLES = 1,
   parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   config_loader_if.slave        s_in,
   output logic [31:0]           o_config_addr,
   output logic [31:0]           o_config_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [15:0]           o_writes_issued
);

   typedef enum logic [2:0] {
      StIdle, StHdr, StAddr, StData, StIssue, StGap, StDone
   } state_e;

   localparam logic [3:0] HoldInit = 4'(HOLD_CYCLES - 1);

   state_e      r_state;
   logic        r_hdr_cnt;
   logic [1:0]  r_byte_cnt;
   logic [3:0]  r_hold_cnt;
   logic [15:0] r_count;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic [15:0] r_writes;
   logic        r_ready;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_cfg_addr;
   logic [31:0] r_cfg_data;

   logic        w_accept;
   logic [15:0] w_count_next;
   logic [31:0] w_data_next;
   logic [15:0] w_writes_inc;

   // r_ready is only ever set in HDR/ADDR/DATA, so it doubles as the accept qualifier.
   assign w_accept     = s_in.in_valid && r_ready;
   // LSB-first assembly: each new byte enters at the top and shifts down.
   assign w_count_next = {s_in.in_data, r_count[15:8]};
   assign w_data_next  = {s_in.in_data, r_data[31:8]};
   assign w_writes_inc = r_writes + 16'd1;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state    <= StIdle;
         r_hdr_cnt  <= 1'b0;
         r_byte_cnt <= 2'd0;
         r_hold_cnt <= 4'd0;
         r_count    <= 16'd0;
         r_addr     <= 32'd0;
         r_data     <= 32'd0;
         r_writes   <= 16'd0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_cfg_addr <= IDLE_ADDR;
         r_cfg_data <= 32'd0;
      end else begin
         // Outputs are registered and updated together with the state they belong to.
         unique case (r_state)
            StIdle, StDone: begin
               if (i_start) begin
                  r_state  <= StHdr;
                  r_writes <= 16'd0;
                  r_ready  <= 1'b1;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
               end
            end
            StHdr: begin
               if (w_accept) begin
                  r_count   <= w_count_next;
                  r_hdr_cnt <= ~r_hdr_cnt;
                  if (r_hdr_cnt) begin
                     if (w_count_next == 16'd0) begin
                        r_state <= StDone;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= StAddr;
                     end
                  end
               end
            end
            StAddr: begin
               if (w_accept) begin
                  r_addr     <= {s_in.in_data, r_addr[31:8]};
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) begin
                     r_state <= StData;
                  end
               end
            end
            StData: begin
               if (w_accept) begin
                  r_data     <= w_data_next;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) begin
                     r_state    <= StIssue;
                     r_ready    <= 1'b0;
                     r_hold_cnt <= HoldInit;
                     r_cfg_addr <= r_addr;
                     r_cfg_data <= w_data_next;
                  end
               end
            end
            StIssue: begin
               if (r_hold_cnt == 4'd0) begin
                  r_state    <= StGap;
                  r_cfg_addr <= IDLE_ADDR;
                  r_cfg_data <= 32'd0;
               end else begin
                  r_hold_cnt <= r_hold_cnt - 4'd1;
               end
            end
            StGap: begin
               r_writes <= w_writes_inc;
               if (w_writes_inc == r_count) begin
                  r_state <= StDone;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= StAddr;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state    <= StIdle;
               r_ready    <= 1'b0;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
               r_cfg_addr <= IDLE_ADDR;
               r_cfg_data <= 32'd0;
            end
         endcase
      end
   end

   assign s_in.in_ready   = r_ready;
   assign o_config_addr   = r_cfg_addr;
   assign o_config_data   = r_cfg_data;
   assign o_busy          = r_busy;
   assign o_done          = r_done;
   assign o_writes_issued = r_writes;

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed bench for config_loader. Three instances (HOLD_CYCLES 1, 2, 4)
// share clock and reset; tb_sel routes stimulus to one instance and its outputs to the monitor.
module tb_config_loader;

   logic        clk;
   logic        reset;
   logic        tb_start;
   logic        tb_valid;
   logic [7:0]  tb_data;
   logic [1:0]  tb_sel;
   logic        stall_en;

   int checks;
   int errors;

   config_loader_if u_if_h1 ();
   config_loader_if u_if_h2 ();
   config_loader_if u_if_h4 ();

   logic [31:0] addr_h1, addr_h2, addr_h4;
   logic [31:0] cdata_h1, cdata_h2, cdata_h4;
   logic        busy_h1, busy_h2, busy_h4;
   logic        done_h1, done_h2, done_h4;
   logic [15:0] wr_h1, wr_h2, wr_h4;

   assign u_if_h1.in_data  = tb_data;
   assign u_if_h2.in_data  = tb_data;
   assign u_if_h4.in_data  = tb_data;
   assign u_if_h1.in_valid = tb_valid && (tb_sel == 2'd0);
   assign u_if_h2.in_valid = tb_valid && (tb_sel == 2'd1);
   assign u_if_h4.in_valid = tb_valid && (tb_sel == 2'd2);

   config_loader #(.HOLD_CYCLES(1)) u_dut_h1 (
      .i_clk(clk), .i_reset(reset), .i_start(tb_start && (tb_sel == 2'd0)), .s_in(u_if_h1),
      .o_config_addr(addr_h1), .o_config_data(cdata_h1), .o_busy(busy_h1), .o_done(done_h1),
      .o_writes_issued(wr_h1)
   );
   config_loader #(.HOLD_CYCLES(2)) u_dut_h2 (
      .i_clk(clk), .i_reset(reset), .i_start(tb_start && (tb_sel == 2'd1)), .s_in(u_if_h2),
      .o_config_addr(addr_h2), .o_config_data(cdata_h2), .o_busy(busy_h2), .o_done(done_h2),
      .o_writes_issued(wr_h2)
   );
   config_loader #(.HOLD_CYCLES(4)) u_dut_h4 (
      .i_clk(clk), .i_reset(reset), .i_start(tb_start && (tb_sel == 2'd2)), .s_in(u_if_h4),
      .o_config_addr(addr_h4), .o_config_data(cdata_h4), .o_busy(busy_h4), .o_done(done_h4),
      .o_writes_issued(wr_h4)
   );

   logic [31:0] w_addr;
   logic [31:0] w_cdata;
   logic        w_ready;
   logic        w_busy;
   logic        w_done;
   logic [15:0] w_writes;

   always_comb begin
      w_addr   = addr_h1;
      w_cdata  = cdata_h1;
      w_ready  = u_if_h1.in_ready;
      w_busy   = busy_h1;
      w_done   = done_h1;
      w_writes = wr_h1;
      if (tb_sel == 2'd1) begin
         w_addr   = addr_h2;
         w_cdata  = cdata_h2;
         w_ready  = u_if_h2.in_ready;
         w_busy   = busy_h2;
         w_done   = done_h2;
         w_writes = wr_h2;
      end else if (tb_sel == 2'd2) begin
         w_addr   = addr_h4;
         w_cdata  = cdata_h4;
         w_ready  = u_if_h4.in_ready;
         w_busy   = busy_h4;
         w_done   = done_h4;
         w_writes = wr_h4;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus monitor: one entry per contiguous run of non-null addresses.
   int          mon_windows = 0;
   logic        mon_prev = 1'b0;
   logic [31:0] win_addr [32];
   logic [31:0] win_data [32];
   int          win_len  [32];

   always @(negedge clk) begin
      if (w_addr != 32'h0) begin
         if (!mon_prev) begin
            if (mon_windows < 32) begin
               win_addr[mon_windows] <= w_addr;
               win_data[mon_windows] <= w_cdata;
               win_len[mon_windows]  <= 1;
            end
            mon_windows <= mon_windows + 1;
         end else if (mon_windows > 0 && mon_windows <= 32) begin
            win_len[mon_windows-1] <= win_len[mon_windows-1] + 1;
         end
      end
      mon_prev <= (w_addr != 32'h0);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte was accepted.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      if (stall_en) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      tb_data  = b;
      tb_valid = 1'b1;
      while (!w_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("send_timeout", 32'(n), 32'd0);
      @(negedge clk);
      tb_valid = 1'b0;
   endtask

   task automatic send_count(input logic [15:0] n);
      send_byte(n[7:0]);
      send_byte(n[15:8]);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic pulse_start();
      tb_start = 1'b1;
      @(negedge clk);
      tb_start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!w_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(w_done), 32'd1);
   endtask

   int base;

   initial begin
      checks   = 0;
      errors   = 0;
      tb_start = 1'b0;
      tb_valid = 1'b0;
      tb_data  = 8'h00;
      tb_sel   = 2'd0;
      stall_en = 1'b0;
      reset    = 1'b0;

      // Reset with garbage on the stream input.
      @(negedge clk);
      tb_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tb_data = 8'($urandom);
         @(negedge clk);
      end
      for (int s = 0; s < 3; s++) begin
         tb_sel = 2'(s);
         #1;
         check("rst_ready", 32'(w_ready), 32'd0);
         check("rst_busy", 32'(w_busy), 32'd0);
         check("rst_done", 32'(w_done), 32'd0);
         check("rst_addr", w_addr, 32'd0);
         check("rst_data", w_cdata, 32'd0);
         check("rst_writes", 32'(w_writes), 32'd0);
      end
      @(negedge clk);
      tb_valid = 1'b0;
      tb_sel   = 2'd0;
      reset    = 1'b1;
      @(negedge clk);

      // Single record, HOLD_CYCLES=1.
      base = mon_windows;
      pulse_start();
      check("start_busy", 32'(w_busy), 32'd1);
      check("start_ready", 32'(w_ready), 32'd1);
      send_count(16'd1);
      send_word(32'h0010_0007);
      send_word(32'h0000_0003);
      check("h1_issue_addr", w_addr, 32'h0010_0007);
      check("h1_issue_data", w_cdata, 32'h0000_0003);
      check("h1_issue_ready", 32'(w_ready), 32'd0);
      @(negedge clk);
      check("h1_gap_addr", w_addr, 32'd0);
      check("h1_gap_data", w_cdata, 32'd0);
      @(negedge clk);
      check("h1_done", 32'(w_done), 32'd1);
      check("h1_writes", 32'(w_writes), 32'd1);
      check("h1_busy", 32'(w_busy), 32'd0);
      check("h1_windows", 32'(mon_windows - base), 32'd1);
      check("h1_win_len", 32'(win_len[base]), 32'd1);

      // Three records, HOLD_CYCLES=2, random stalls.
      tb_sel   = 2'd1;
      stall_en = 1'b1;
      base     = mon_windows;
      pulse_start();
      send_count(16'd3);
      send_word(32'h0001_0002);
      send_word(32'hAABB_CCDD);
      repeat (3) @(negedge clk);
      check("h2_writes1", 32'(w_writes), 32'd1);
      send_word(32'h0002_0005);
      send_word(32'h1234_5678);
      repeat (3) @(negedge clk);
      check("h2_writes2", 32'(w_writes), 32'd2);
      send_word(32'h0003_0001);
      send_word(32'hCAFE_F00D);
      repeat (3) @(negedge clk);
      check("h2_writes3", 32'(w_writes), 32'd3);
      check("h2_done", 32'(w_done), 32'd1);
      check("h2_windows", 32'(mon_windows - base), 32'd3);
      check("h2_w0_addr", win_addr[base], 32'h0001_0002);
      check("h2_w0_data", win_data[base], 32'hAABB_CCDD);
      check("h2_w0_len", 32'(win_len[base]), 32'd2);
      check("h2_w1_addr", win_addr[base+1], 32'h0002_0005);
      check("h2_w1_data", win_data[base+1], 32'h1234_5678);
      check("h2_w1_len", 32'(win_len[base+1]), 32'd2);
      check("h2_w2_addr", win_addr[base+2], 32'h0003_0001);
      check("h2_w2_data", win_data[base+2], 32'hCAFE_F00D);
      check("h2_w2_len", 32'(win_len[base+2]), 32'd2);
      stall_en = 1'b0;

      // Empty stream on the HOLD_CYCLES=1 instance, which is sitting in DONE.
      tb_sel = 2'd0;
      base   = mon_windows;
      pulse_start();
      check("empty_wr_clr", 32'(w_writes), 32'd0);
      send_count(16'd0);
      check("empty_done", 32'(w_done), 32'd1);
      check("empty_busy", 32'(w_busy), 32'd0);
      check("empty_windows", 32'(mon_windows - base), 32'd0);

      // Reset on the 2nd hold cycle, HOLD_CYCLES=4, then a clean reload.
      tb_sel = 2'd2;
      base   = mon_windows;
      pulse_start();
      send_count(16'd1);
      send_word(32'h0004_0009);
      send_word(32'h0000_0055);
      check("h4_hold1_addr", w_addr, 32'h0004_0009);
      @(negedge clk);
      check("h4_hold2_addr", w_addr, 32'h0004_0009);
      reset = 1'b0;
      @(negedge clk);
      check("h4_rst_addr", w_addr, 32'd0);
      check("h4_rst_data", w_cdata, 32'd0);
      check("h4_rst_busy", 32'(w_busy), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      pulse_start();
      send_count(16'd1);
      send_word(32'h0007_0003);
      send_word(32'h0000_0099);
      wait_done("h4_done");
      check("h4_writes", 32'(w_writes), 32'd1);
      check("h4_windows", 32'(mon_windows - base), 32'd2);
      check("h4_cut_len", 32'(win_len[base]), 32'd2);
      check("h4_win_addr", win_addr[base+1], 32'h0007_0003);
      check("h4_win_data", win_data[base+1], 32'h0000_0099);
      check("h4_win_len", 32'(win_len[base+1]), 32'd4);

      // start while in DATA is ignored; start in DONE restarts. The HOLD_CYCLES=2 instance
      // was reset above, so it starts from IDLE.
      tb_sel = 2'd1;
      base   = mon_windows;
      pulse_start();
      send_count(16'd1);
      send_word(32'h0005_000A);
      send_byte(8'h44);
      send_byte(8'h33);
      pulse_start();
      check("ign_busy", 32'(w_busy), 32'd1);
      check("ign_ready", 32'(w_ready), 32'd1);
      send_byte(8'h22);
      send_byte(8'h11);
      wait_done("ign_done");
      check("ign_writes", 32'(w_writes), 32'd1);
      check("ign_windows", 32'(mon_windows - base), 32'd1);
      check("ign_win_addr", win_addr[base], 32'h0005_000A);
      check("ign_win_data", win_data[base], 32'h1122_3344);
      pulse_start();
      check("restart_writes", 32'(w_writes), 32'd0);
      check("restart_busy", 32'(w_busy), 32'd1);
      check("restart_ready", 32'(w_ready), 32'd1);
      check("restart_done", 32'(w_done), 32'd0);
      send_count(16'd0);
      check("restart_end", 32'(w_done), 32'd1);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
